// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings
// and the responder FSM state type.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering for the data memory: extracts and extends the
// addressed byte/half/word on the read side, and merges store data into the
// old word on the write side. Purely combinational.
module dmem_lane_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_unsigned,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Read side: select the addressed lane (offset 0 is the MSB lane) and extend
    always_comb begin
        w_byte = i_word[31:24];
        case (i_off)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_off[1] ? i_word[15:0] : i_word[31:16];
        case (i_size)
            SZ_BYTE: o_rdata = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_rdata = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_rdata = i_word;
        endcase
    end

    // Write side: replace only the addressed lanes of the old word
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_off)
                    2'd0:    o_merged[31:24] = i_wdata[7:0];
                    2'd1:    o_merged[23:16] = i_wdata[7:0];
                    2'd2:    o_merged[15:8]  = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_off[1]) begin
                    o_merged[15:0] = i_wdata[15:0];
                end else begin
                    o_merged[31:16] = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 2,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_err,
  output logic        hold_mem
);

  localparam int unsigned CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  dmem_state_t r_state;
  dmem_state_t w_next;
  logic [CW-1:0] r_cnt;

  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] r_rdata;
  logic        r_ready;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic        w_we;
  logic        w_uns;
  logic [1:0]  w_size;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_word;
  logic [31:0] w_ld;
  logic [31:0] w_merged;
  logic        w_enter_resp;

  // IDLE uses the live ports so a zero-wait access completes on the accepting edge
  always_comb begin
    if (r_state == IDLE) begin
      w_we    = we;
      w_uns   = unsigned_ld;
      w_size  = size;
      w_addr  = addr;
      w_wdata = wdata;
    end else begin
      w_we    = r_we;
      w_uns   = r_uns;
      w_size  = r_size;
      w_addr  = r_addr;
      w_wdata = r_wdata;
    end
  end

  always_comb begin
    w_err = 1'b0;
    case (w_size)
      SZ_BYTE: w_err = 1'b0;
      SZ_HALF: w_err = w_addr[0];
      SZ_WORD: w_err = |w_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if ({2'b00, w_addr[31:2]} >= DEPTH) begin
      w_err = 1'b1;
    end
  end

  assign w_idx  = w_addr[AW+1:2];
  assign w_word = r_mem[w_idx];

  dmem_lane_align u_align (
    .i_word     (w_word),
    .i_wdata    (w_wdata),
    .i_size     (w_size),
    .i_off      (w_addr[1:0]),
    .i_unsigned (w_uns),
    .o_rdata    (w_ld),
    .o_merged   (w_merged)
  );

  always_comb begin
    w_next   = r_state;
    hold_mem = 1'b0;
    case (r_state)
      IDLE: begin
        if (req) begin
          hold_mem = 1'b1;
          w_next   = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        hold_mem = 1'b1;
        if (r_cnt == '0) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_enter_resp = (w_next == RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp & w_err;
      if (r_state == IDLE && req) begin
        r_we    <= we;
        r_uns   <= unsigned_ld;
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cnt   <= CNT_LOAD;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_enter_resp && !w_we) begin
        r_rdata <= w_err ? '0 : w_ld;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter_resp && w_we && !w_err) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  assign rdata    = r_rdata;
  assign ready    = r_ready;
  assign addr_err = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-addressed reference model
// predicts each response, a monitor compares whenever ready pulses.
module tb_dmem_responder;
    import mips_mem_pkg::*;

    localparam int WS = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req = 0, we = 0, uns = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [31:0] rdata;
    logic        ready, addr_err, hold_mem;

    logic        req0 = 0, we0 = 0, uns0 = 0;
    logic [1:0]  size0 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0;
    logic [31:0] rdata0;
    logic        ready0, addr_err0, hold0;

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(WS), .INIT_FILE("")) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .unsigned_ld(uns),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .addr_err(addr_err), .hold_mem(hold_mem)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .size(size0), .unsigned_ld(uns0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0),
        .addr_err(addr_err0), .hold_mem(hold0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    logic [7:0]  mb [0:63];
    logic [31:0] model_rd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fault(input logic [1:0] sz, input logic [31:0] a);
        if (a[31:2] >= 30'd1024) return 1'b1;
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Lowest byte address is the most significant byte of the value
    function automatic logic [31:0] m_load(input logic [1:0] sz, input bit u, input logic [31:0] a);
        int n = 1 << sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(mb[int'(a[5:0]) + i]);
        if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int n = 1 << sz;
        for (int i = 0; i < n; i++) mb[int'(a[5:0]) + i] = 8'(d >> (8*(n-1-i)));
    endfunction

    // Issue one transaction on u_dut starting at a negedge; returns at the negedge after RESP
    task automatic txn(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                       input logic [31:0] d, input bit use_exp, input logic [31:0] exp_rd);
        exp_t e;
        bit f;
        int k;
        f = m_fault(sz, a);
        if (!w) model_rd = f ? 32'h0 : m_load(sz, u, a);
        else if (!f) m_store(sz, a, d);
        e.rd  = use_exp ? exp_rd : model_rd;
        e.err = f;
        sb_q.push_back(e);
        req = 1; we = w; size = sz; uns = u; addr = a; wdata = d;
        #1 check("hold_on_req", 32'(hold_mem), 32'd1);
        @(negedge clk);
        req = 0;
        k = 1;
        while (ready !== 1'b1 && k < 12) begin
            check("hold_in_wait", 32'(hold_mem), 32'd1);
            @(negedge clk);
            k++;
        end
        if (ready !== 1'b1) begin
            check("ready_timeout", 32'(ready), 32'd1);
        end else begin
            check("latency", 32'(k), 32'(1 + WS));
            check("hold_in_resp", 32'(hold_mem), 32'd0);
        end
        @(negedge clk);
    endtask

    // Monitor: every ready pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (rst === 1'b1 && ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'(ready), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("rdata", rdata, e.rd);
                check("addr_err", 32'(addr_err), 32'(e.err));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(addr_err), 32'd0);
        check("rst_hold", 32'(hold_mem), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);

        // Known contents for words 0..15
        for (int i = 0; i < 16; i++) txn(1, SZ_WORD, 0, 32'(i*4), $urandom, 0, 0);

        // Word store/load, sub-word loads with both extensions
        txn(1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 0, 0);
        txn(0, SZ_WORD, 0, 32'h10, 0, 1, 32'hDEADBEEF);
        txn(0, SZ_BYTE, 0, 32'h11, 0, 1, 32'hFFFFFFAD);
        txn(0, SZ_BYTE, 1, 32'h11, 0, 1, 32'h000000AD);
        txn(0, SZ_HALF, 0, 32'h12, 0, 1, 32'hFFFFBEEF);
        // Byte merge keeps the other lanes
        txn(1, SZ_BYTE, 0, 32'h13, 32'h00000055, 0, 0);
        txn(0, SZ_WORD, 0, 32'h10, 0, 1, 32'hDEADBE55);
        // Misaligned accesses fault and do not disturb memory
        txn(0, SZ_WORD, 0, 32'h12, 0, 1, 32'h0);
        txn(1, SZ_HALF, 0, 32'h11, 32'h0000AAAA, 1, 32'h0);
        txn(0, SZ_WORD, 0, 32'h10, 0, 1, 32'hDEADBE55);
        // Out of range word index
        txn(0, SZ_WORD, 0, 32'h1000, 0, 1, 32'h0);
        txn(1, SZ_WORD, 0, 32'h1000, 32'h11111111, 1, 32'h0);
        txn(0, SZ_WORD, 0, 32'h10, 0, 1, 32'hDEADBE55);

        // Reset in the middle of a store's wait period
        req = 1; we = 1; size = SZ_WORD; uns = 0; addr = 32'h20; wdata = 32'h12345678;
        @(negedge clk);
        req = 0;
        #2 rst = 0;
        #1;
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_err", 32'(addr_err), 32'd0);
        check("midrst_hold_lo", 32'(hold_mem), 32'd0);
        req = 1;
        #1 check("midrst_hold_req", 32'(hold_mem), 32'd1);
        req = 0;
        model_rd = '0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        txn(0, SZ_WORD, 0, 32'h20, 0, 0, 0);

        // Zero wait states: ready one cycle after req, every second cycle with req held
        req0 = 1; we0 = 1; size0 = SZ_WORD; uns0 = 0; addr0 = 32'h4; wdata0 = 32'hCAFEF00D;
        #1 check("ws0_hold_req", 32'(hold0), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check("ws0_ready", 32'(ready0), 32'(k % 2));
            check("ws0_hold", 32'(hold0), 32'((k + 1) % 2));
        end
        we0 = 0;
        @(negedge clk);
        req0 = 0;
        check("ws0_ld_ready", 32'(ready0), 32'd1);
        check("ws0_ld_rdata", rdata0, 32'hCAFEF00D);
        check("ws0_ld_err", 32'(addr_err0), 32'd0);
        @(negedge clk);

        // Randomised traffic
        for (int t = 0; t < 200; t++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) a = $urandom | 32'h1000;
            else a = 32'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0, 0);
        end

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
